inst_fetch_queue: RTL and testbench

Instruction prefetch queue between the instruction-fetch stage and the instruction-decode stage. Buffers up to DEPTH fetched {PC, instruction} pairs, so fetch keeps running while decode stalls. Valid/ready handshake on both sides. A flush input discards all buffered entries on a taken branch.

---
 rtl/inst_fetch_queue_pkg.sv | 14 +
 rtl/ifq_storage.sv | 23 ++
 rtl/inst_fetch_queue.sv | 106 ++++++++++
 tb/tb_inst_fetch_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode pipeline definitions: default widths, NOP encoding, fetch-entry type.
package inst_fetch_queue_pkg;

   localparam int unsigned DEF_INST_SIZE = 32;
   localparam int unsigned DEF_PC_SIZE   = 32;

   localparam logic [DEF_INST_SIZE-1:0] NOP_INST = 32'd0;

   typedef struct packed {
      logic [DEF_PC_SIZE-1:0]   pc;
      logic [DEF_INST_SIZE-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one asynchronous read port.
module ifq_storage #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [WIDTH-1:0]         wrData,
   input  logic [$clog2(DEPTH)-1:0] rdAddr,
   output logic [WIDTH-1:0]         rdData
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; pointers and count qualify validity.
   always_ff @(posedge clk) begin
      if (wrEn) r_mem[wrAddr] <= wrData;
   end

   assign rdData = r_mem[rdAddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue between fetch and decode, flushable on redirect.
// Define IFQ_BYPASS_EN for a zero-latency fall-through path when the queue is empty.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned INST_SIZE = DEF_INST_SIZE,
   parameter int unsigned PC_SIZE   = DEF_PC_SIZE,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inValid,
   input  logic [PC_SIZE-1:0]         inPC,
   input  logic [INST_SIZE-1:0]       inInstruction,
   output logic                       inReady,
   output logic                       outValid,
   output logic [PC_SIZE-1:0]         outPC,
   output logic [INST_SIZE-1:0]       outInstruction,
   input  logic                       outReady,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH+1);
   localparam int unsigned ENTRY_W = PC_SIZE + INST_SIZE;

   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic [ENTRY_W-1:0] w_rd_data;
   logic               w_empty, w_full, w_bypass, w_push, w_pop, w_wr_en, w_rd_adv;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
   // Gated by rst so nothing appears at the output while reset is held.
   assign w_bypass = rst & w_empty & inValid & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign inReady  = ~w_full;
   assign outValid = (~w_empty | w_bypass) & ~flush;
   assign w_push   = inValid & inReady & ~flush;
   assign w_pop    = outValid & outReady & ~flush;

   // A bypassed entry consumed in the same cycle never touches storage.
   assign w_wr_en  = w_push & ~(w_bypass & outReady);
   assign w_rd_adv = w_pop & ~w_empty;

   always_comb begin
      outPC          = w_rd_data[ENTRY_W-1:INST_SIZE];
      outInstruction = w_empty ? INST_SIZE'(NOP_INST) : w_rd_data[INST_SIZE-1:0];
      if (w_bypass) begin
         outPC          = inPC;
         outInstruction = inInstruction;
      end
   end

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_wr_en)  w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
         if (w_rd_adv) w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
         case ({w_wr_en, w_rd_adv})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   assign count = r_count;

   ifq_storage #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk    (clk),
      .wrEn   (w_wr_en),
      .wrAddr (r_wr_ptr),
      .wrData ({inPC, inInstruction}),
      .rdAddr (r_rd_ptr),
      .rdData (w_rd_data)
   );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue; reference is a queue of {pc, instruction} entries.
// Define IFQ_BYPASS_EN for both RTL and bench to cover the fall-through build.
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid, outReady, flush;
   logic [31:0] inPC, inInstruction;
   logic        inReady, outValid;
   logic [31:0] outPC, outInstruction;
   logic [2:0]  count;

   int          n_asserts = 0;
   int          n_fail    = 0;
   logic [63:0] q[$];
   logic [31:0] last_pc;
   logic        last_ov;

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .INST_SIZE (32),
      .PC_SIZE   (32),
      .DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .inValid        (inValid),
      .inPC           (inPC),
      .inInstruction  (inInstruction),
      .inReady        (inReady),
      .outValid       (outValid),
      .outPC          (outPC),
      .outInstruction (outInstruction),
      .outReady       (outReady),
      .flush          (flush),
      .count          (count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs against the reference queue, then advance it.
   task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      logic [31:0] ins;
      logic        exp_ov, exp_ir, byp, pop, push;
      logic [63:0] exp_head;
      ins           = $urandom;
      inValid       = v;
      inPC          = pc;
      inInstruction = ins;
      outReady      = ordy;
      flush         = fl;
      #3;
      byp = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = (q.size() == 0) && v && !fl;
`endif
      exp_ir = (q.size() != DEPTH);
      exp_ov = (q.size() != 0 || byp) && !fl;
      chk("count", 64'(count), 64'(q.size()));
      chk("count_bound", 64'(count <= DEPTH), 64'd1);
      chk("inReady", 64'(inReady), 64'(exp_ir));
      chk("outValid", 64'(outValid), 64'(exp_ov));
      last_ov = outValid;
      last_pc = outPC;
      if (exp_ov) begin
         exp_head = byp ? {pc, ins} : q[0];
         chk("outPC", 64'(outPC), 64'(exp_head[63:32]));
         chk("outInstruction", 64'(outInstruction), 64'(exp_head[31:0]));
      end
      if (fl) begin
         q.delete();
      end else begin
         pop  = exp_ov && ordy;
         push = v && exp_ir;
         if (!(byp && pop)) begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({pc, ins});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      rst = 1'b0; inValid = 1'b1; inPC = 32'h0; inInstruction = 32'h0;
      outReady = 1'b0; flush = 1'b0;

      // Reset held with a valid input presented
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_outValid", 64'(outValid), 64'd0);
         chk("rst_inReady", 64'(inReady), 64'd1);
      end
      rst = 1'b1;
      step(1'b1, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("first_push_valid", 64'(last_ov), 64'd1);
      chk("first_push_pc", 64'(last_pc), 64'h0);

      // Fill then drain
      step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_inReady", 64'(inReady), 64'd0);
      step(1'b1, 32'h10, 1'b0, 1'b0);
      chk("refused_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         chk("drain_pc", 64'(last_pc), 64'(4 * i));
      end
      chk("drained_count", 64'(count), 64'd0);

      // Streaming at count 2 across pointer wraps
      step(1'b1, 32'h100, 1'b0, 1'b0);
      step(1'b1, 32'h104, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'h108 + 32'(4 * i), 1'b1, 1'b0);
         chk("stream_pc", 64'(last_pc), 64'h100 + 64'(4 * i));
         chk("stream_count", 64'(count), 64'd2);
      end

      // Flush with simultaneous push and pop
      step(1'b1, 32'h200, 1'b0, 1'b0);
      chk("pre_flush_count", 64'(count), 64'd3);
      step(1'b1, 32'h204, 1'b1, 1'b1);
      chk("flush_outValid", 64'(last_ov), 64'd0);
      chk("post_flush_count", 64'(count), 64'd0);
      step(1'b1, 32'h40, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("post_flush_pc", 64'(last_pc), 64'h40);

      // Full with pop: push refused
      for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      step(1'b1, 32'h310, 1'b1, 1'b0);
      chk("full_pop_count", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef IFQ_BYPASS_EN
      step(1'b1, 32'h20, 1'b1, 1'b0);
      chk("byp_valid", 64'(last_ov), 64'd1);
      chk("byp_pc", 64'(last_pc), 64'h20);
      chk("byp_count", 64'(count), 64'd0);
      step(1'b1, 32'h20, 1'b0, 1'b0);
      chk("byp_store_count", 64'(count), 64'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

      // Randomized traffic
      pc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 9) < 7), pc, 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 19) == 0));
         pc += 32'd4;
      end

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      inValid = 1'b0;
      outReady = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_outValid", 64'(outValid), 64'd0);
      chk("async_rst_inReady", 64'(inReady), 64'd1);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, 32'h600, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("after_rst_pc", 64'(last_pc), 64'h600);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
